// File: rtl/playback_if.sv
// Handshake/control bundle between the playback controller and the display, buttons and frame loader.
// Controller side drives the load request and status; environment drives vsync, buttons and load_ack.
interface playback_if #(
    parameter int FRAME_W = 13
);
    logic               vsync;
    logic               btn_play;
    logic               btn_restart;
    logic               load_req;
    logic               load_ack;
    logic [FRAME_W-1:0] frame_idx;
    logic               playing;
    logic               done;

    modport master (
        input  vsync, btn_play, btn_restart, load_ack,
        output load_req, frame_idx, playing, done
    );

    modport slave (
        output vsync, btn_play, btn_restart, load_ack,
        input  load_req, frame_idx, playing, done
    );
endinterface

// File: rtl/playback_controller.sv
// Frame sequencer: paces frame advances on vsync edges and issues a req/ack load per frame.
// All outputs registered (one cycle after the deciding input); load_req held until load_ack.
module playback_controller #(
    parameter int NUM_FRAMES      = 6572,
    parameter int FRAME_W         = 13,
    parameter int VSYNC_PER_FRAME = 2,
    parameter int LOOP            = 0
) (
    input  logic      clk,
    input  logic      reset,
    playback_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_PAUSED,
        S_DONE
    } state_t;

    localparam logic [FRAME_W-1:0] LAST_IDX  = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [7:0]         VCNT_LAST = 8'(VSYNC_PER_FRAME - 1);

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [7:0]         vcnt_q, vcnt_d;
    logic               pend_pause_q, pend_pause_d;
    logic               pend_restart_q, pend_restart_d;
    logic               req_gap_q, req_gap_d;
    logic               vsync_prev_q;
    logic               load_req_q, playing_q, done_q;

    logic               vsync_edge;
    logic               pause_eff;
    logic               restart_eff;

    assign vsync_edge  = bus.vsync & ~vsync_prev_q;
    // Button pulses arriving on the ack cycle still count toward the pending decision.
    assign pause_eff   = pend_pause_q ^ bus.btn_play;
    assign restart_eff = pend_restart_q | bus.btn_restart;

    always_comb begin
        state_d        = state_q;
        frame_d        = frame_q;
        vcnt_d         = vcnt_q;
        pend_pause_d   = pend_pause_q;
        pend_restart_d = pend_restart_q;
        req_gap_d      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.btn_restart || bus.btn_play) begin
                    state_d = S_LOAD;
                    frame_d = '0;
                    vcnt_d  = '0;
                end
            end

            S_LOAD: begin
                pend_pause_d   = pause_eff;
                pend_restart_d = restart_eff;
                // During the one-cycle request gap after a restart no load is outstanding.
                if (!req_gap_q && bus.load_ack) begin
                    pend_pause_d   = 1'b0;
                    pend_restart_d = 1'b0;
                    vcnt_d         = '0;
                    if (restart_eff) begin
                        frame_d   = '0;
                        req_gap_d = 1'b1;
                    end else if (pause_eff) begin
                        state_d = S_PAUSED;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (bus.btn_restart) begin
                    state_d = S_LOAD;
                    frame_d = '0;
                    vcnt_d  = '0;
                end else if (bus.btn_play) begin
                    state_d = S_PAUSED;
                end else if (vsync_edge) begin
                    if (vcnt_q < VCNT_LAST) begin
                        vcnt_d = vcnt_q + 8'd1;
                    end else if (frame_q < LAST_IDX) begin
                        state_d = S_LOAD;
                        frame_d = frame_q + FRAME_W'(1);
                        vcnt_d  = '0;
                    end else if (LOOP != 0) begin
                        state_d = S_LOAD;
                        frame_d = '0;
                        vcnt_d  = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_PAUSED: begin
                if (bus.btn_restart) begin
                    state_d = S_LOAD;
                    frame_d = '0;
                    vcnt_d  = '0;
                end else if (bus.btn_play) begin
                    state_d = S_WAIT;
                    vcnt_d  = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            frame_q        <= '0;
            vcnt_q         <= '0;
            pend_pause_q   <= 1'b0;
            pend_restart_q <= 1'b0;
            req_gap_q      <= 1'b0;
            vsync_prev_q   <= 1'b1;
            load_req_q     <= 1'b0;
            playing_q      <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_q        <= frame_d;
            vcnt_q         <= vcnt_d;
            pend_pause_q   <= pend_pause_d;
            pend_restart_q <= pend_restart_d;
            req_gap_q      <= req_gap_d;
            vsync_prev_q   <= bus.vsync;
            load_req_q     <= (state_d == S_LOAD) && !req_gap_d;
            playing_q      <= (state_d == S_LOAD) || (state_d == S_WAIT);
            done_q         <= (state_d == S_DONE);
        end
    end

    assign bus.load_req  = load_req_q;
    assign bus.frame_idx = frame_q;
    assign bus.playing   = playing_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_playback_controller.sv
// Directed bench: dut_a (8 frames, stop) for sequencing/pause/restart/reset; dut_b/dut_c (4 frames,
// stop vs loop) share stimulus for end-of-video behaviour.
module tb_playback_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic a_vsync, a_play, a_restart, a_ack;
    logic b_vsync, b_play, b_restart, b_ack;

    playback_if #(.FRAME_W(13)) if_a ();
    playback_if #(.FRAME_W(13)) if_b ();
    playback_if #(.FRAME_W(13)) if_c ();

    assign if_a.vsync       = a_vsync;
    assign if_a.btn_play    = a_play;
    assign if_a.btn_restart = a_restart;
    assign if_a.load_ack    = a_ack;
    assign if_b.vsync       = b_vsync;
    assign if_b.btn_play    = b_play;
    assign if_b.btn_restart = b_restart;
    assign if_b.load_ack    = b_ack;
    assign if_c.vsync       = b_vsync;
    assign if_c.btn_play    = b_play;
    assign if_c.btn_restart = b_restart;
    assign if_c.load_ack    = b_ack;

    playback_controller #(.NUM_FRAMES(8), .FRAME_W(13), .VSYNC_PER_FRAME(2), .LOOP(0))
        dut_a (.clk(clk), .reset(rst), .bus(if_a));
    playback_controller #(.NUM_FRAMES(4), .FRAME_W(13), .VSYNC_PER_FRAME(2), .LOOP(0))
        dut_b (.clk(clk), .reset(rst), .bus(if_b));
    playback_controller #(.NUM_FRAMES(4), .FRAME_W(13), .VSYNC_PER_FRAME(2), .LOOP(1))
        dut_c (.clk(clk), .reset(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int vs, pl, rs, ack;
        int req, idx, play, dn;
    } vec_t;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic req, input logic [12:0] idx,
                           input logic play, input logic dn,
                           input int e_req, input int e_idx, input int e_play, input int e_dn);
        chk({name, "/load_req"},  32'(req),  e_req);
        chk({name, "/frame_idx"}, 32'(idx),  e_idx);
        chk({name, "/playing"},   32'(play), e_play);
        chk({name, "/done"},      32'(dn),   e_dn);
    endtask

    task automatic chk_a(input string name, input int e_req, input int e_idx, input int e_play, input int e_dn);
        chk_out(name, if_a.load_req, if_a.frame_idx, if_a.playing, if_a.done, e_req, e_idx, e_play, e_dn);
    endtask

    task automatic edge_a();
        a_vsync = 1'b1; cyc();
        a_vsync = 1'b0; cyc();
    endtask

    task automatic ack_a();
        a_ack = 1'b1; cyc();
        a_ack = 1'b0;
    endtask

    task automatic edge_b();
        b_vsync = 1'b1; cyc();
        b_vsync = 1'b0; cyc();
    endtask

    initial begin
        vec_t tbl[19];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_vsync = 1'b1; a_play = 1'b0; a_restart = 1'b0; a_ack = 1'b0;
        b_vsync = 1'b0; b_play = 1'b0; b_restart = 1'b0; b_ack = 1'b0;

        //          vs pl rs ack  req idx play done
        tbl[0]  = '{1, 0, 0, 0,   0,  0,  0,   0};
        tbl[1]  = '{1, 1, 0, 0,   1,  0,  1,   0};
        tbl[2]  = '{1, 0, 0, 0,   1,  0,  1,   0};
        tbl[3]  = '{1, 0, 0, 0,   1,  0,  1,   0};
        tbl[4]  = '{1, 0, 0, 0,   1,  0,  1,   0};
        tbl[5]  = '{1, 0, 0, 0,   1,  0,  1,   0};
        tbl[6]  = '{1, 0, 0, 1,   0,  0,  1,   0};
        tbl[7]  = '{0, 0, 0, 0,   0,  0,  1,   0};
        tbl[8]  = '{1, 0, 0, 0,   0,  0,  1,   0};
        tbl[9]  = '{0, 0, 0, 0,   0,  0,  1,   0};
        tbl[10] = '{1, 0, 0, 0,   1,  1,  1,   0};
        tbl[11] = '{0, 0, 0, 0,   1,  1,  1,   0};
        tbl[12] = '{1, 0, 0, 0,   1,  1,  1,   0};
        tbl[13] = '{1, 0, 0, 1,   0,  1,  1,   0};
        tbl[14] = '{0, 0, 0, 0,   0,  1,  1,   0};
        tbl[15] = '{1, 0, 0, 0,   0,  1,  1,   0};
        tbl[16] = '{0, 0, 0, 0,   0,  1,  1,   0};
        tbl[17] = '{1, 0, 0, 0,   1,  2,  1,   0};
        tbl[18] = '{0, 0, 0, 1,   0,  2,  1,   0};

        repeat (3) cyc();
        chk_a("reset", 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            a_vsync   = 1'(tbl[i].vs);
            a_play    = 1'(tbl[i].pl);
            a_restart = 1'(tbl[i].rs);
            a_ack     = 1'(tbl[i].ack);
            cyc();
            chk_a($sformatf("vec%0d", i), tbl[i].req, tbl[i].idx, tbl[i].play, tbl[i].dn);
        end
        a_vsync = 1'b0; a_play = 1'b0; a_restart = 1'b0; a_ack = 1'b0;

        // Pause on the same cycle as the due vsync edge: the advance is discarded.
        edge_a();
        a_vsync = 1'b1; a_play = 1'b1; cyc();
        a_vsync = 1'b0; a_play = 1'b0; cyc();
        chk_a("pause_on_due", 0, 2, 0, 0);
        for (int i = 0; i < 10; i++) begin
            edge_a();
            chk(.name($sformatf("paused_edge%0d/load_req", i)), .act(32'(if_a.load_req)), .exp(0));
        end
        chk_a("paused_hold", 0, 2, 0, 0);
        a_play = 1'b1; cyc(); a_play = 1'b0;
        chk_a("resume", 0, 2, 1, 0);
        edge_a();
        chk_a("resume_edge1", 0, 2, 1, 0);
        edge_a();
        chk_a("resume_edge2", 1, 3, 1, 0);
        ack_a();

        // Reach LOAD for frame 5, then pause+restart before the ack: restart wins.
        edge_a(); edge_a(); ack_a();
        edge_a(); edge_a();
        chk_a("load5", 1, 5, 1, 0);
        a_play = 1'b1; cyc(); a_play = 1'b0;
        cyc();
        a_restart = 1'b1; cyc(); a_restart = 1'b0;
        chk_a("load5_pending", 1, 5, 1, 0);
        ack_a();
        chk_a("restart_gap", 0, 0, 1, 0);
        cyc();
        chk_a("restart_rereq", 1, 0, 1, 0);
        cyc();
        chk_a("restart_hold", 1, 0, 1, 0);
        ack_a();
        chk_a("restart_wait", 0, 0, 1, 0);
        edge_a(); edge_a();
        chk_a("not_paused", 1, 1, 1, 0);

        // Reset while a request is outstanding, then a stray ack in IDLE.
        rst = 1'b1; cyc(); rst = 1'b0;
        chk_a("reset_in_load", 0, 0, 0, 0);
        ack_a();
        chk_a("late_ack", 0, 0, 0, 0);
        cyc();
        chk_a("idle_stable", 0, 0, 0, 0);

        // Restart beats a coincident play and due vsync advance in WAIT.
        a_play = 1'b1; cyc(); a_play = 1'b0;
        ack_a();
        edge_a();
        a_vsync = 1'b1; a_play = 1'b1; a_restart = 1'b1; cyc();
        a_vsync = 1'b0; a_play = 1'b0; a_restart = 1'b0;
        chk_a("restart_priority", 1, 0, 1, 0);

        // End of video: LOOP=0 stops in DONE, LOOP=1 wraps to frame 0.
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        b_play = 1'b1; cyc(); b_play = 1'b0;
        b_ack = 1'b1; cyc(); b_ack = 1'b0;
        for (int f = 1; f < 4; f++) begin
            edge_b(); edge_b();
            chk_out($sformatf("b_frame%0d", f), if_b.load_req, if_b.frame_idx, if_b.playing, if_b.done, 1, f, 1, 0);
            chk_out($sformatf("c_frame%0d", f), if_c.load_req, if_c.frame_idx, if_c.playing, if_c.done, 1, f, 1, 0);
            b_ack = 1'b1; cyc(); b_ack = 1'b0;
        end
        edge_b(); edge_b();
        chk_out("b_done", if_b.load_req, if_b.frame_idx, if_b.playing, if_b.done, 0, 3, 0, 1);
        chk_out("c_wrap", if_c.load_req, if_c.frame_idx, if_c.playing, if_c.done, 1, 0, 1, 0);
        b_ack = 1'b1; cyc(); b_ack = 1'b0;
        chk_out("b_done_ack", if_b.load_req, if_b.frame_idx, if_b.playing, if_b.done, 0, 3, 0, 1);
        b_play = 1'b1; cyc(); b_play = 1'b0;
        chk_out("b_replay", if_b.load_req, if_b.frame_idx, if_b.playing, if_b.done, 1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
